// File: rtl/instr_mem_fetch.sv
// Instruction memory for the IF stage.
// After reset, the block clears its own memory. It then returns one registered
// instruction per cycle and accepts program-load writes on a separate port.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   pc           byte address of the fetch
//   stall        hold instr/instr_valid/fetch_fault
//   flush        kill the fetch and drive NOP_WORD
//   instr        registered instruction
//   instr_valid  instr holds a real fetched word
//   fetch_fault  last fetch was misaligned or out of range
//   ready        self-clear finished; fetch and load are live
//   ld_we        program-load write strobe
//   ld_addr      word index; MSB set marks it out of range
//   ld_data      word to write
//   ld_ack       one-cycle pulse, write committed
//   ld_err       one-cycle pulse, write rejected
module instr_mem_fetch #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 256,
    parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              pc,
    input  logic                     stall,
    input  logic                     flush,
    output logic [DATA_W-1:0]        instr,
    output logic                     instr_valid,
    output logic                     fetch_fault,
    output logic                     ready,
    input  logic                     ld_we,
    input  logic [$clog2(DEPTH):0]   ld_addr,
    input  logic [DATA_W-1:0]        ld_data,
    output logic                     ld_ack,
    output logic                     ld_err
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic                valid_q, valid_d;
    logic                fault_q, fault_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic                mem_we;
    logic [AW-1:0]       mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    logic [AW-1:0]       fetch_idx;
    logic                addr_fault;

    assign fetch_idx  = pc[AW+1:2];
    assign addr_fault = (pc[1:0] != 2'b00) || (pc[31:AW+2] != '0);

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
            instr_q   <= NOP_WORD;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    // Memory contents are not reset; only the clear sequence initialises them.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            StClear: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LastIdx) begin
                    state_d = StRun;
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StClear;
        endcase
    end

    // Output and memory-port logic
    always_comb begin
        instr_d   = instr_q;
        valid_d   = valid_q;
        fault_d   = fault_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = clr_cnt_q;
        mem_wdata = NOP_WORD;
        case (state_q)
            StClear: begin
                mem_we = 1'b1;
            end
            StRun: begin
                if (ld_we) begin
                    if (ld_addr[AW]) begin
                        err_d = 1'b1;
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = ld_addr[AW-1:0];
                        mem_wdata = ld_data;
                        ack_d     = 1'b1;
                    end
                end
                // The read uses the pre-edge array, so a same-cycle load of the
                // same word returns the old contents.
                if (flush) begin
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                    fault_d = 1'b0;
                end else if (!stall) begin
                    if (addr_fault) begin
                        instr_d = NOP_WORD;
                        valid_d = 1'b0;
                        fault_d = 1'b1;
                    end else begin
                        instr_d = mem[fetch_idx];
                        valid_d = 1'b1;
                        fault_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign fetch_fault = fault_q;
    assign ready       = (state_q == StRun);
    assign ld_ack      = ack_q;
    assign ld_err      = err_q;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Scoreboard bench for instr_mem_fetch.
// The driver applies inputs on the falling edge and pushes the expected response
// computed by a word-array reference model. The monitor pops one entry after each
// rising edge and compares it with the outputs.
module tb_instr_mem_fetch;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fetch_fault;
    logic        ready;
    logic        ld_we = 1'b0;
    logic [8:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        ld_ack;
    logic        ld_err;

    instr_mem_fetch #(
        .DATA_W   (32),
        .DEPTH    (DEPTH),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc          (pc),
        .stall       (stall),
        .flush       (flush),
        .instr       (instr),
        .instr_valid (instr_valid),
        .fetch_fault (fetch_fault),
        .ready       (ready),
        .ld_we       (ld_we),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_ack      (ld_ack),
        .ld_err      (ld_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        fault;
        logic        ack;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          n_run = 0;
    int          n_fail = 0;

    // Reference model: program words plus the currently presented fetch result
    logic [31:0] model_mem [DEPTH];
    logic [31:0] m_instr = '0;
    logic        m_valid = 1'b0;
    logic        m_fault = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_run++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endfunction

    task automatic model_reset();
        m_instr = '0;
        m_valid = 1'b0;
        m_fault = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    // One cycle of stimulus and the response it should produce after the next edge
    task automatic drive(input logic [31:0] p, input logic s, input logic f,
                         input logic w, input logic [8:0] a, input logic [31:0] d);
        exp_t e;
        @(negedge clk);
        pc      = p;
        stall   = s;
        flush   = f;
        ld_we   = w;
        ld_addr = a;
        ld_data = d;
        if (f) begin
            m_instr = '0;
            m_valid = 1'b0;
            m_fault = 1'b0;
        end else if (!s) begin
            if ((p % 4) != 0 || p >= DEPTH * 4) begin
                m_instr = '0;
                m_valid = 1'b0;
                m_fault = 1'b1;
            end else begin
                m_instr = model_mem[p / 4];
                m_valid = 1'b1;
                m_fault = 1'b0;
            end
        end
        e.instr = m_instr;
        e.valid = m_valid;
        e.fault = m_fault;
        e.ack   = w && (a < DEPTH);
        e.err   = w && (a >= DEPTH);
        if (e.ack) model_mem[a] = d;
        exp_q.push_back(e);
    endtask

    task automatic fetch(input logic [31:0] p);
        drive(p, 1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_instr"}, instr, 32'h0);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
        check({tag, "_ready"}, {31'd0, ready}, 32'd0);
        check({tag, "_ack"},   {31'd0, ld_ack}, 32'd0);
        check({tag, "_err"},   {31'd0, ld_err}, 32'd0);
    endtask

    // Monitor
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("instr",       instr, e.instr);
            check("instr_valid", {31'd0, instr_valid}, {31'd0, e.valid});
            check("fetch_fault", {31'd0, fetch_fault}, {31'd0, e.fault});
            check("ld_ack",      {31'd0, ld_ack}, {31'd0, e.ack});
            check("ld_err",      {31'd0, ld_err}, {31'd0, e.err});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        logic [31:0] p;
        logic [8:0]  a;
        model_reset();

        // Reset held for three cycles
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Clear sequence; load and fetch inputs must be ignored
        rst_n   = 1'b1;
        pc      = 32'h4;
        ld_we   = 1'b1;
        ld_addr = 9'd5;
        ld_data = 32'hffff_ffff;
        for (int i = 1; i <= DEPTH; i++) begin
            @(posedge clk);
            #1;
            check("clear_ready", {31'd0, ready}, {31'd0, (i == DEPTH)});
            check("clear_instr", instr, 32'h0);
            check("clear_valid", {31'd0, instr_valid}, 32'd0);
            check("clear_ack",   {31'd0, ld_ack}, 32'd0);
        end

        // Program load and in-order fetch
        drive(32'h0, 1'b0, 1'b0, 1'b1, 9'd0, 32'h8c01_0004);
        drive(32'h0, 1'b0, 1'b0, 1'b1, 9'd1, 32'h8c02_000c);
        drive(32'h0, 1'b0, 1'b0, 1'b1, 9'd2, 32'h8c03_0014);
        drive(32'h0, 1'b0, 1'b0, 1'b1, 9'd3, 32'h8c04_001c);
        fetch(32'h0);
        fetch(32'h4);
        fetch(32'h8);
        fetch(32'hc);
        // The word written during clear must still read as zero
        fetch(32'h14);

        // Stall holds, release fetches the new pc
        fetch(32'h4);
        repeat (3) drive(32'h8, 1'b1, 1'b0, 1'b0, 9'd0, 32'd0);
        fetch(32'h8);

        // Flush beats stall, then misaligned and out-of-range faults
        drive(32'h8, 1'b1, 1'b1, 1'b0, 9'd0, 32'd0);
        fetch(32'h6);
        fetch(32'h400);
        // Stall holds a faulted result
        drive(32'h0, 1'b1, 1'b0, 1'b0, 9'd0, 32'd0);

        // Read-before-write on the same word, then rejected load
        drive(32'h8, 1'b0, 1'b0, 1'b1, 9'd2, 32'h50a6_03ff);
        fetch(32'h8);
        drive(32'hc, 1'b0, 1'b0, 1'b1, 9'h100, 32'hdead_beef);
        fetch(32'h0);
        // Load proceeds under flush and stall
        drive(32'h0, 1'b1, 1'b1, 1'b1, 9'd7, 32'h1234_5678);
        fetch(32'h1c);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0:       p = ($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(1, 3);
                1:       p = $urandom | 32'h400;
                default: p = $urandom_range(0, 15) << 2;
            endcase
            if ($urandom_range(0, 7) == 0) a = 9'h100 | 9'($urandom_range(0, 255));
            else                           a = 9'($urandom_range(0, 15));
            drive(p, ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 2) == 0), a, $urandom);
        end

        // Reset mid-stream with a load in flight
        drive(32'h0, 1'b0, 1'b0, 1'b1, 9'd3, 32'hcafe_f00d);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        model_reset();
        ld_we = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_noack", {31'd0, ld_ack}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        while (!ready && cnt < 300) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("clear_len", cnt, DEPTH);
        fetch(32'h0);
        fetch(32'h8);
        fetch(32'hc);
        @(posedge clk);
        #2;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
